// File: rtl/window_receiver_pkg.sv
// Shared types and constants for the window receiver slice.
package window_receiver_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned WIN_DIM     = 15;
    localparam int unsigned WIN_SIZE    = WIN_DIM * WIN_DIM;
    localparam int unsigned SUM_W       = 16;
    localparam int unsigned NUM_WIN     = 9202;
    localparam int unsigned IDX_W       = 14;
    localparam int unsigned ARM_TIMEOUT = 16;
    localparam int unsigned TMO_W       = $clog2(ARM_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ARM,
        ST_COLLECT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/window_receiver_if.sv
// Command, fetcher-stream and result signals of the window receiver.
// Optional max_out is present when WINDOW_RECEIVER_MAXPOOL_EN is defined.
interface window_receiver_if;
    import window_receiver_pkg::*;

    logic              start;
    logic              busy;
    logic              req_out;
    logic [CNT_W-1:0]  win_count;
    logic [DATA_W-1:0] win_data;
    logic              win_valid;
    logic [SUM_W-1:0]  sum_out;
    logic              result_valid;
    logic [IDX_W-1:0]  win_index;
    logic              seq_err;
`ifdef WINDOW_RECEIVER_MAXPOOL_EN
    logic [DATA_W-1:0] max_out;
`endif

    modport master (
        output start, win_count, win_data, win_valid,
        input  busy, req_out, sum_out, result_valid, win_index, seq_err
`ifdef WINDOW_RECEIVER_MAXPOOL_EN
        , input max_out
`endif
    );

    modport slave (
        input  start, win_count, win_data, win_valid,
        output busy, req_out, sum_out, result_valid, win_index, seq_err
`ifdef WINDOW_RECEIVER_MAXPOOL_EN
        , output max_out
`endif
    );

endinterface

// File: rtl/window_accum.sv
// Window accumulator: running sum, expected-index counter and index compare.
// Running max is included when WINDOW_RECEIVER_MAXPOOL_EN is defined.
module window_accum
    import window_receiver_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic              valid_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              match_c_o,
    output logic              last_c_o,
    output logic [SUM_W-1:0]  sum_next_c_o
`ifdef WINDOW_RECEIVER_MAXPOOL_EN
    ,
    output logic [DATA_W-1:0] max_next_c_o
`endif
);

    logic [SUM_W-1:0] sum_q, sum_d, sum_base;
    logic [CNT_W-1:0] exp_q, exp_d, exp_base;
`ifdef WINDOW_RECEIVER_MAXPOOL_EN
    logic [DATA_W-1:0] max_q, max_d;
`endif

    // Clear forces a fresh window; an accept on the same cycle loads the first pixel.
    always_comb begin
        sum_base = clear_i ? '0 : sum_q;
        exp_base = clear_i ? '0 : exp_q;
        sum_d    = en_i ? sum_base + SUM_W'(data_i) : sum_base;
        exp_d    = en_i ? exp_base + CNT_W'(1) : exp_base;
`ifdef WINDOW_RECEIVER_MAXPOOL_EN
        max_d = clear_i ? '0 : max_q;
        if (en_i && (clear_i || data_i > max_q)) begin
            max_d = data_i;
        end
`endif
    end

    assign match_c_o    = valid_i && (count_i == exp_base);
    assign last_c_o     = (count_i == CNT_W'(WIN_SIZE - 1));
    assign sum_next_c_o = sum_d;
`ifdef WINDOW_RECEIVER_MAXPOOL_EN
    assign max_next_c_o = max_d;
`endif

    // Accumulator state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            exp_q <= '0;
`ifdef WINDOW_RECEIVER_MAXPOOL_EN
            max_q <= '0;
`endif
        end else begin
            sum_q <= sum_d;
            exp_q <= exp_d;
`ifdef WINDOW_RECEIVER_MAXPOOL_EN
            max_q <= max_d;
`endif
        end
    end

endmodule

// File: rtl/window_receiver.sv
// Window receiver: requests one window, checks the 0..WIN_SIZE-1 index stream
// and publishes its pixel sum. WINDOW_RECEIVER_MAXPOOL_EN adds max_out.
module window_receiver #(
    parameter int unsigned NUM_WIN = window_receiver_pkg::NUM_WIN
) (
    input  logic               clk,
    input  logic               rst,
    window_receiver_if.slave   bus
);
    import window_receiver_pkg::*;

    state_e            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              busy_q, req_q, rv_q, seq_err_q;
    logic [SUM_W-1:0]  sum_q;
    logic [IDX_W-1:0]  win_index_q;
    logic              clear_c, en_c, err_c, done_c;
    logic              match_c, last_c;
    logic [SUM_W-1:0]  sum_next_c;
`ifdef WINDOW_RECEIVER_MAXPOOL_EN
    logic [DATA_W-1:0] max_q, max_next_c;
`endif

    window_accum u_accum (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear_c),
        .en_i         (en_c),
        .valid_i      (bus.win_valid),
        .count_i      (bus.win_count),
        .data_i       (bus.win_data),
        .match_c_o    (match_c),
        .last_c_o     (last_c),
        .sum_next_c_o (sum_next_c)
`ifdef WINDOW_RECEIVER_MAXPOOL_EN
        ,
        .max_next_c_o (max_next_c)
`endif
    );

    // Next-state and control decode.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        clear_c = (state_q != ST_COLLECT);
        en_c    = 1'b0;
        err_c   = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_REQ;
            end
            ST_REQ: begin
                tmo_d   = '0;
                state_d = ST_ARM;
            end
            ST_ARM: begin
                if (match_c) begin
                    en_c    = 1'b1;
                    state_d = ST_COLLECT;
                end else if (tmo_q == TMO_W'(ARM_TIMEOUT - 1)) begin
                    err_c   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_COLLECT: begin
                if (match_c) begin
                    en_c = 1'b1;
                    if (last_c) begin
                        done_c  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    err_c   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; results land as the last index is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            busy_q      <= 1'b0;
            req_q       <= 1'b0;
            rv_q        <= 1'b0;
            seq_err_q   <= 1'b0;
            sum_q       <= '0;
            win_index_q <= '0;
`ifdef WINDOW_RECEIVER_MAXPOOL_EN
            max_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            busy_q  <= (state_d != ST_IDLE);
            req_q   <= (state_d == ST_REQ);
            rv_q    <= done_c;
            if (err_c) seq_err_q <= 1'b1;
            if (done_c) begin
                sum_q       <= sum_next_c;
                win_index_q <= (win_index_q == IDX_W'(NUM_WIN - 1)) ? '0
                                                                    : win_index_q + IDX_W'(1);
`ifdef WINDOW_RECEIVER_MAXPOOL_EN
                max_q       <= max_next_c;
`endif
            end
        end
    end

    assign bus.busy         = busy_q;
    assign bus.req_out      = req_q;
    assign bus.result_valid = rv_q;
    assign bus.seq_err      = seq_err_q;
    assign bus.sum_out      = sum_q;
    assign bus.win_index    = win_index_q;
`ifdef WINDOW_RECEIVER_MAXPOOL_EN
    assign bus.max_out      = max_q;
`endif

endmodule
